// File: rtl/fir_multi_pkg.sv
// Shared types and constants for the multi-channel FIR: FSM states,
// per-band coefficient tables (stored as Q1.15) and accumulator sizing.
package fir_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_e;

  localparam int COEF_TAB_LEN = 8;

  // Band 1: symmetric 8-tap low-pass with unity DC gain; taps beyond the table are zero.
  localparam logic signed [15:0] BAND1_Q15 [COEF_TAB_LEN] = '{
    16'sh0200, 16'sh0A00, 16'sh1600, 16'sh1E00,
    16'sh1E00, 16'sh1600, 16'sh0A00, 16'sh0200
  };

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Returns coef[k] of the given band rescaled from Q1.15 to Q1.(coef_w-1).
  function automatic logic signed [31:0] coef_scaled(input int band, input int k, input int coef_w);
    logic signed [31:0] q15;
    case (band)
      1:       q15 = (k < COEF_TAB_LEN) ? 32'(BAND1_Q15[k[2:0]]) : 32'sd0;
      default: q15 = 32'sh0000_4000;
    endcase
    if (coef_w >= 16) return q15 <<< (coef_w - 16);
    else              return q15 >>> (16 - coef_w);
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup for one band, sized to COEF_W.
module fir_coef_rom
  import fir_multi_pkg::*;
#(
  parameter int BAND   = 0,
  parameter int TAPS   = 32,
  parameter int COEF_W = 16
) (
  input  logic        [$clog2(TAPS)-1:0] addr_i,
  output logic signed [COEF_W-1:0]       coef_o
);

  always_comb begin
    coef_o = COEF_W'(coef_scaled(BAND, int'(addr_i), COEF_W));
  end

endmodule

// File: rtl/fir_multi_chan.sv
// Time-multiplexed multi-channel FIR: one MAC per cycle over all channels/taps.
// Define FIR_MULTI_CHAN_SAT_EN to saturate results; otherwise they wrap.
//
// state | meaning
// IDLE  | ready for a frame; on accept write history, advance wr_ptr
// MAC   | one multiply-accumulate per cycle, channel-major, tap-minor
// ROUND | reduce the last channel's accumulator
// OUT   | load filt_out, pulse filt_vld, return to IDLE
module fir_multi_chan
  import fir_multi_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int TAPS     = 32,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int BAND     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_W-1:0]   smpl_in,
  input  logic                         smpl_vld,
  output logic                         smpl_rdy,
  output logic [CHANNELS*DATA_W-1:0]   filt_out,
  output logic                         filt_vld
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PTR_W = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(TAPS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [PTR_W:0]   RD_OFS   = (PTR_W + 1)'(TAPS - 1);
  localparam logic [PTR_W:0]   TAPS_EXT = (PTR_W + 1)'(TAPS);
`ifdef FIR_MULTI_CHAN_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  fir_state_e state_q, state_d;

  logic        [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic        [PTR_W-1:0]  tap_q, tap_d;
  logic        [CH_W-1:0]   ch_q, ch_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] hist_q [CHANNELS][TAPS];
  logic signed [DATA_W-1:0] hist_d [CHANNELS][TAPS];
  logic        [DATA_W-1:0] res_q  [CHANNELS];
  logic        [DATA_W-1:0] res_d  [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] filt_out_q, filt_out_d;
  logic                       filt_vld_q, filt_vld_d;

  logic                             accept;
  logic        [PTR_W:0]            rd_sum;
  logic        [PTR_W-1:0]          rd_addr;
  logic signed [DATA_W-1:0]         smpl_rd;
  logic signed [COEF_W-1:0]         coef;
  logic signed [DATA_W+COEF_W-1:0]  prod;
  logic signed [ACC_W-1:0]          prod_ext;

  function automatic logic [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] acc);
`ifdef FIR_MULTI_CHAN_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> (COEF_W - 1);
    if (shifted > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (shifted < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return shifted[DATA_W-1:0];
`else
    return DATA_W'(acc >>> (COEF_W - 1));
`endif
  endfunction

  fir_coef_rom #(
    .BAND   (BAND),
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_coef_rom (
    .addr_i (tap_q),
    .coef_o (coef)
  );

  // wr_ptr has already advanced past the newest sample, so tap k sits at wr_ptr-1-k.
  always_comb begin
    rd_sum = {1'b0, wr_ptr_q} + RD_OFS - {1'b0, tap_q};
    if (rd_sum >= TAPS_EXT) rd_sum = rd_sum - TAPS_EXT;
  end

  assign rd_addr  = rd_sum[PTR_W-1:0];
  assign smpl_rd  = hist_q[ch_q][rd_addr];
  assign prod     = smpl_rd * coef;
  assign prod_ext = ACC_W'(prod);
  assign accept   = smpl_vld && smpl_rdy;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_MAC;
      ST_MAC:   if (tap_q == LAST_TAP && ch_q == LAST_CH) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    smpl_rdy = (state_q == ST_IDLE) && !rst;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    tap_d      = tap_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    hist_d     = hist_q;
    res_d      = res_q;
    filt_out_d = filt_out_q;
    filt_vld_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          for (int c = 0; c < CHANNELS; c++) begin
            hist_d[c][wr_ptr_q] = smpl_in[c*DATA_W +: DATA_W];
          end
          wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
          tap_d    = '0;
          ch_d     = '0;
        end
      end
      ST_MAC: begin
        // First tap of a channel restarts the sum and retires the previous channel.
        if (tap_q == '0) begin
          acc_d = prod_ext;
          if (ch_q != '0) res_d[ch_q - 1'b1] = reduce(acc_q);
        end else begin
          acc_d = acc_q + prod_ext;
        end
        if (tap_q == LAST_TAP) begin
          tap_d = '0;
          ch_d  = ch_q + 1'b1;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      ST_ROUND: res_d[LAST_CH] = reduce(acc_q);
      ST_OUT: begin
        for (int c = 0; c < CHANNELS; c++) begin
          filt_out_d[c*DATA_W +: DATA_W] = res_q[c];
        end
        filt_vld_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      tap_q      <= '0;
      ch_q       <= '0;
      acc_q      <= '0;
      filt_out_q <= '0;
      filt_vld_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        res_q[c] <= '0;
        for (int k = 0; k < TAPS; k++) hist_q[c][k] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      tap_q      <= tap_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      filt_out_q <= filt_out_d;
      filt_vld_q <= filt_vld_d;
      res_q      <= res_d;
      hist_q     <= hist_d;
    end
  end

  assign filt_out = filt_out_q;
  assign filt_vld = filt_vld_q;

endmodule

// File: doc/fir_multi_chan.md
FIR_MULTI_CHAN -- requirements
Module: fir_multi_chan

Interface
REQ-001 The block SHALL provide parameter CHANNELS, default 2: number of audio channels filtered.
REQ-002 The block SHALL provide parameter TAPS, default 32, minimum 2: filter length per channel.
REQ-003 The block SHALL provide parameter DATA_W, default 16: signed sample width.
REQ-004 The block SHALL provide parameter COEF_W, default 16: signed Q1.(COEF_W-1) coefficient width.
REQ-005 The block SHALL provide parameter BAND, default 0: coefficient set index (0 = test set, coef[k]=0.5 for all k).
REQ-006 The block SHALL provide port clk, input, 1 bit: single clock; all logic on posedge.
REQ-007 The block SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL provide port smpl_in, input, CHANNELS*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W]; channel 0 is left.
REQ-009 The block SHALL provide port smpl_vld, input, 1 bit: a sample frame is offered.
REQ-010 The block SHALL provide port smpl_rdy, output, 1 bit: the block accepts the frame this cycle.
REQ-011 The block SHALL provide port filt_out, output, CHANNELS*DATA_W bits: filtered frame, same packing as smpl_in.
REQ-012 The block SHALL provide port filt_vld, output, 1 bit: one-cycle pulse; filt_out is updated in the same cycle.

Function
REQ-013 A frame SHALL be accepted on a cycle where smpl_vld && smpl_rdy; offers made while smpl_rdy=0 SHALL be ignored, and the source holds them.
REQ-014 The FSM SHALL have states IDLE, MAC, ROUND and OUT; smpl_rdy SHALL be 1 only in IDLE.
REQ-015 On acceptance, the block SHALL write each channel's sample into its circular history at wr_ptr, then move IDLE->MAC.
REQ-016 MAC SHALL perform exactly one multiply-accumulate per cycle, channel-major and tap-minor, for CHANNELS*TAPS cycles, then move to ROUND.
REQ-017 Tap k SHALL multiply the sample accepted k frames ago (k=0 is newest) by coef[k].
REQ-018 The accumulator SHALL be DATA_W+COEF_W+$clog2(TAPS) bits signed, so no internal overflow is possible.
REQ-019 The accumulator SHALL be cleared at the start of each channel.
REQ-020 The channel result SHALL be acc >>> (COEF_W-1), reduced to DATA_W bits per REQ-030/031.
REQ-021 ROUND SHALL last one cycle; OUT SHALL last one cycle, loading filt_out, asserting filt_vld and returning to IDLE.
REQ-022 Latency SHALL be CHANNELS*TAPS+2 cycles from the accept edge to filt_vld high.
REQ-023 wr_ptr SHALL advance once per accepted frame and wrap from TAPS-1 to 0 for any TAPS, power of two or not.
REQ-024 Tap read addressing SHALL wrap modulo TAPS.
REQ-025 filt_out SHALL hold its value between filt_vld pulses.
REQ-026 Before TAPS frames have been accepted, missing history SHALL read as zero.

Reset
REQ-027 While rst=1, the block SHALL set: state=IDLE, filt_out=0, filt_vld=0, smpl_rdy=0, wr_ptr=0, accumulator=0 and all history entries=0.
REQ-028 smpl_rdy SHALL be 1 on the first cycle after rst falls.
REQ-029 rst asserted mid-MAC SHALL abort the computation with no filt_vld pulse and discard all history.

Configuration
REQ-030 With macro FIR_MULTI_CHAN_SAT_EN defined, each channel result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-031 Without FIR_MULTI_CHAN_SAT_EN, each result SHALL be truncated to its low DATA_W bits (two's-complement wrap).

Structure
REQ-032 Package fir_multi_pkg SHALL hold the FSM state enum, the per-BAND coefficient tables and the accumulator-width constant function.
REQ-033 Sub-module fir_coef_rom (BAND, TAPS, COEF_W) SHALL return coef[addr] combinationally from the package tables.
REQ-034 The history SHALL be a register array cleared by reset, not an inferred RAM.

Verification (CHANNELS=2, TAPS=4, DATA_W=16, COEF_W=16, BAND=0)
REQ-035 Reset check: assert rst for 3 cycles mid-stream -> filt_out=0, filt_vld=0, smpl_rdy=0 during reset; smpl_rdy=1 on the next cycle; no filt_vld follows.
REQ-036 Impulse: left 0x2000 then zeros, right 0 throughout -> left outputs 0x1000 for 4 frames, then 0x0000; right stays 0x0000; filt_vld exactly 10 cycles after each accept.
REQ-037 Back-pressure: hold smpl_vld=1 continuously -> one accept per 11 cycles; no frame lost or duplicated across a 6-frame sequence (covers wr_ptr wrap).
REQ-038 Saturation: all inputs 0x7FFF for 4+ frames -> output 0x7FFF with FIR_MULTI_CHAN_SAT_EN; 0xFFFE without it.
REQ-039 Negative full scale: all inputs 0x8000 -> output 0x8000 with the macro; 0x0000 without it.
REQ-040 Channel independence: left +0x1000 and right -0x1000 constant for 4 frames -> filt_out left 0x2000, right 0xE000.
